// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS architectural-state dumper: dumper FSM
// states, register-file geometry, memory word geometry and the beat record
// held in the output slot.
// -----------------------------------------------------------------------------
package mips_pkg;

    // Number of architectural general-purpose registers dumped first.
    localparam int REG_COUNT      = 32;

    // Memory bytes packed into one memory beat.
    localparam int BYTES_PER_WORD = 4;

    // Dumper sequencing states.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        REGS       = 3'd1,
        MEM_GATHER = 3'd2,
        MEM_WAIT   = 3'd3,
        FINISH     = 3'd4
    } dump_state_e;

    // One output beat: payload plus sideband tags.
    typedef struct packed {
        logic [31:0] data;
        logic        kind;   // 0 = register beat, 1 = memory-word beat
        logic [7:0]  index;  // register number or memory word index
        logic        last;   // final beat of the dump
    } dump_beat_t;

endpackage

// File: rtl/mips_state_dumper_packer.sv
// -----------------------------------------------------------------------------
// dump_word_packer
// Collects data-memory bytes one per cycle into a 32-bit big-endian word.
// The byte at the lowest address ends up in bits 31:24. A word completes on
// its 4th byte or early on the final valid byte of memory; lanes that were
// never filled read as zero, which zero-pads the final partial word.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clear          discard any partially gathered word
//   shift_en       byte_in is valid this cycle and is consumed
//   byte_in        next memory byte (ascending addresses)
//   final_byte     byte_in is the last byte of memory; force completion
//   word_out       word formed by the bytes so far plus byte_in
//   word_complete  word_out is a finished word this cycle
// -----------------------------------------------------------------------------
module dump_word_packer
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    input  logic        final_byte,
    output logic [31:0] word_out,
    output logic        word_complete
);

    localparam logic [1:0] LANE_LAST = 2'(BYTES_PER_WORD - 1);

    // Earlier bytes of the current word; newest byte sits in the low lane.
    logic [23:0] acc_q;
    logic [23:0] acc_d;
    // Number of bytes already held in acc_q.
    logic [1:0]  lane_q;
    logic [1:0]  lane_d;

    // Left-justify held bytes plus the incoming byte so unfilled lanes are zero.
    always_comb begin
        word_out = 32'h0000_0000;
        case (lane_q)
            2'd0:    word_out = {byte_in, 24'h00_0000};
            2'd1:    word_out = {acc_q[7:0], byte_in, 16'h0000};
            2'd2:    word_out = {acc_q[15:0], byte_in, 8'h00};
            2'd3:    word_out = {acc_q[23:0], byte_in};
            default: word_out = 32'h0000_0000;
        endcase
        word_complete = shift_en & ((lane_q == LANE_LAST) | final_byte);
    end

    // Next-state for the shift register and lane counter.
    always_comb begin
        acc_d  = acc_q;
        lane_d = lane_q;
        if (clear) begin
            acc_d  = 24'h00_0000;
            lane_d = 2'd0;
        end else if (word_complete) begin
            // The completed word leaves via word_out; start the next one empty.
            acc_d  = 24'h00_0000;
            lane_d = 2'd0;
        end else if (shift_en) begin
            acc_d  = {acc_q[15:0], byte_in};
            lane_d = lane_q + 2'd1;
        end else begin
            acc_d  = acc_q;
            lane_d = lane_q;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= 24'h00_0000;
            lane_q <= 2'd0;
        end else begin
            acc_q  <= acc_d;
            lane_q <= lane_d;
        end
    end

endmodule

// File: rtl/mips_state_dumper.sv
// -----------------------------------------------------------------------------
// mips_state_dumper
// On a start request, streams the MIPS architectural state out over a
// valid/ready beat interface: registers 0..31 first (one beat each), then the
// first MEM_BYTES bytes of data memory packed big-endian into 32-bit words
// (final partial word zero-padded). done pulses one cycle after the final
// beat is accepted.
//
// Parameters:
//   MEM_BYTES    number of data-memory bytes dumped (1..1024)
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle dump request (honoured only when idle)
//   busy, done   dump in progress / one-cycle completion pulse
//   reg_rd_addr  register-file read index;  reg_rd_data returns combinationally
//   mem_rd_addr  data-memory byte address;  mem_rd_data returns combinationally
//   dump_valid/dump_ready  beat handshake
//   dump_data/kind/index/last  beat payload and tags
// -----------------------------------------------------------------------------
module mips_state_dumper
    import mips_pkg::*;
#(
    parameter int MEM_BYTES = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  reg_rd_addr,
    input  logic [31:0] reg_rd_data,
    output logic [9:0]  mem_rd_addr,
    input  logic [7:0]  mem_rd_data,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [31:0] dump_data,
    output logic        dump_kind,
    output logic [7:0]  dump_index,
    output logic        dump_last
);

    // The byte address counter is one bit wider than mem_rd_addr so it can
    // reach MEM_BYTES = 1024, the "all bytes read" value.
    localparam logic [10:0] MEM_END  = 11'(MEM_BYTES);
    localparam logic [10:0] MEM_LAST = 11'(MEM_BYTES - 1);
    localparam logic [4:0]  REG_LAST = 5'(REG_COUNT - 1);

    dump_state_e state_q;
    dump_state_e state_d;
    logic        busy_q;
    logic        busy_d;
    logic        done_q;
    logic        done_d;
    logic        valid_q;
    logic        valid_d;
    dump_beat_t  slot_q;
    dump_beat_t  slot_d;
    dump_beat_t  pend_q;   // completed memory word waiting for the slot
    dump_beat_t  pend_d;
    logic [4:0]  reg_addr_q;
    logic [4:0]  reg_addr_d;
    logic [10:0] mem_addr_q;
    logic [10:0] mem_addr_d;

    logic        handshake_s;
    logic        loadable_s;
    logic        pk_clear_s;
    logic        pk_shift_s;
    logic        pk_final_s;
    logic [31:0] pk_word_s;
    logic        pk_complete_s;
    dump_beat_t  reg_beat_s;
    dump_beat_t  mem_beat_s;

    dump_word_packer u_packer (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (pk_clear_s),
        .shift_en      (pk_shift_s),
        .byte_in       (mem_rd_data),
        .final_byte    (pk_final_s),
        .word_out      (pk_word_s),
        .word_complete (pk_complete_s)
    );

    // Handshake qualification and the candidate beats for the slot.
    always_comb begin
        handshake_s = valid_q & dump_ready;
        loadable_s  = ~valid_q | dump_ready;
        pk_final_s  = (mem_addr_q == MEM_LAST);

        reg_beat_s.data  = reg_rd_data;
        reg_beat_s.kind  = 1'b0;
        reg_beat_s.index = {3'b000, reg_addr_q};
        reg_beat_s.last  = 1'b0;

        // Word index is the byte address / 4 of any byte in the word.
        mem_beat_s.data  = pk_word_s;
        mem_beat_s.kind  = 1'b1;
        mem_beat_s.index = mem_addr_q[9:2];
        mem_beat_s.last  = pk_final_s;
    end

    // FSM next-state, slot loading and read-address sequencing.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        valid_d    = valid_q;
        slot_d     = slot_q;
        pend_d     = pend_q;
        reg_addr_d = reg_addr_q;
        mem_addr_d = mem_addr_q;
        pk_clear_s = 1'b0;
        pk_shift_s = 1'b0;

        // An accepted beat empties the slot unless a new one is loaded below.
        if (handshake_s) begin
            valid_d = 1'b0;
            slot_d  = '0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            IDLE: begin
                // reg_addr_q is held at 0 here so register 0 is on
                // reg_rd_data in the very cycle start arrives.
                reg_addr_d = 5'd0;
                mem_addr_d = 11'd0;
                if (start) begin
                    slot_d     = reg_beat_s;
                    valid_d    = 1'b1;
                    busy_d     = 1'b1;
                    reg_addr_d = 5'd1;
                    pk_clear_s = 1'b1;
                    state_d    = REGS;
                end else begin
                    busy_d = 1'b0;
                end
            end

            REGS: begin
                if (loadable_s) begin
                    slot_d  = reg_beat_s;
                    valid_d = 1'b1;
                    if (reg_addr_q == REG_LAST) begin
                        reg_addr_d = 5'd0;
                        state_d    = MEM_GATHER;
                    end else begin
                        reg_addr_d = reg_addr_q + 5'd1;
                    end
                end else begin
                    reg_addr_d = reg_addr_q;
                end
            end

            MEM_GATHER: begin
                if (mem_addr_q < MEM_END) begin
                    pk_shift_s = 1'b1;
                    mem_addr_d = mem_addr_q + 11'd1;
                    if (pk_complete_s) begin
                        if (loadable_s) begin
                            slot_d  = mem_beat_s;
                            valid_d = 1'b1;
                        end else begin
                            pend_d  = mem_beat_s;
                            state_d = MEM_WAIT;
                        end
                    end else begin
                        pend_d = pend_q;
                    end
                end else if (handshake_s && slot_q.last) begin
                    // Every byte is read and the final beat just left.
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = FINISH;
                end else begin
                    state_d = MEM_GATHER;
                end
            end

            MEM_WAIT: begin
                if (loadable_s) begin
                    slot_d  = pend_q;
                    valid_d = 1'b1;
                    state_d = MEM_GATHER;
                end else begin
                    state_d = MEM_WAIT;
                end
            end

            FINISH: begin
                reg_addr_d = 5'd0;
                mem_addr_d = 11'd0;
                state_d    = IDLE;
            end

            default: begin
                busy_d     = 1'b0;
                valid_d    = 1'b0;
                slot_d     = '0;
                reg_addr_d = 5'd0;
                mem_addr_d = 11'd0;
                state_d    = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            slot_q     <= '0;
            pend_q     <= '0;
            reg_addr_q <= 5'd0;
            mem_addr_q <= 11'd0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            slot_q     <= slot_d;
            pend_q     <= pend_d;
            reg_addr_q <= reg_addr_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign reg_rd_addr = reg_addr_q;
    assign mem_rd_addr = mem_addr_q[9:0];
    assign dump_valid  = valid_q;
    assign dump_data   = slot_q.data;
    assign dump_kind   = slot_q.kind;
    assign dump_index  = slot_q.index;
    assign dump_last   = slot_q.last;

endmodule

// File: tb/tb_mips_state_dumper.sv
module tb_mips_state_dumper;

    typedef struct packed {
        logic        kind;
        logic [7:0]  idx;
        logic [31:0] data;
        logic        last;
    } tb_beat_t;

    typedef struct {
        bit       sel;    // 0 = 100-byte instance, 1 = 6-byte instance
        int       beat;
        tb_beat_t exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] regs [32];
    logic [7:0]  mem  [1024];

    // Instance A: MEM_BYTES = 100
    logic        rst_n_a = 1'b1, start_a = 1'b0, ready_a = 1'b1;
    logic        busy_a, done_a, valid_a, kind_a, last_a;
    logic [4:0]  reg_addr_a;
    logic [9:0]  mem_addr_a;
    logic [31:0] data_a;
    logic [7:0]  index_a;
    // Instance B: MEM_BYTES = 6
    logic        rst_n_b = 1'b1, start_b = 1'b0, ready_b = 1'b1;
    logic        busy_b, done_b, valid_b, kind_b, last_b;
    logic [4:0]  reg_addr_b;
    logic [9:0]  mem_addr_b;
    logic [31:0] data_b;
    logic [7:0]  index_b;

    mips_state_dumper #(.MEM_BYTES(100)) u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .start(start_a), .busy(busy_a), .done(done_a),
        .reg_rd_addr(reg_addr_a), .reg_rd_data(regs[reg_addr_a]),
        .mem_rd_addr(mem_addr_a), .mem_rd_data(mem[mem_addr_a]),
        .dump_valid(valid_a), .dump_ready(ready_a), .dump_data(data_a),
        .dump_kind(kind_a), .dump_index(index_a), .dump_last(last_a)
    );

    mips_state_dumper #(.MEM_BYTES(6)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .start(start_b), .busy(busy_b), .done(done_b),
        .reg_rd_addr(reg_addr_b), .reg_rd_data(regs[reg_addr_b]),
        .mem_rd_addr(mem_addr_b), .mem_rd_data(mem[mem_addr_b]),
        .dump_valid(valid_b), .dump_ready(ready_b), .dump_data(data_b),
        .dump_kind(kind_b), .dump_index(index_b), .dump_last(last_b)
    );

    function automatic tb_beat_t mk(logic k, logic [7:0] i, logic [31:0] d, logic l);
        tb_beat_t b;
        b.kind = k; b.idx = i; b.data = d; b.last = l;
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- beat monitors (sample on the falling edge) ----------------
    tb_beat_t log_a[$], log_b[$], first_a[$], first_b[$];
    int       lcyc_a[$], lcyc_b[$];
    int       done_cnt_a = 0, done_cnt_b = 0, done_cyc_a = 0, done_cyc_b = 0;
    logic [1:0] done_flags_a = 2'b00, done_flags_b = 2'b00;

    initial begin
        tb_beat_t cur, prev;
        bit       stalled;
        stalled = 1'b0;
        prev    = '0;
        forever begin
            @(negedge clk);
            cur = mk(kind_a, index_a, data_a, last_a);
            if (stalled && rst_n_a)
                chk("stable_payload_a", {21'd0, valid_a, cur}, {21'd0, 1'b1, prev});
            if (valid_a && ready_a) begin
                log_a.push_back(cur);
                lcyc_a.push_back(cyc);
            end
            if (done_a) begin
                done_cnt_a++;
                done_cyc_a   = cyc;
                done_flags_a = {busy_a, valid_a};
            end
            stalled = valid_a && !ready_a && rst_n_a;
            prev    = cur;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (valid_b && ready_b) begin
                log_b.push_back(mk(kind_b, index_b, data_b, last_b));
                lcyc_b.push_back(cyc);
            end
            if (done_b) begin
                done_cnt_b++;
                done_cyc_b   = cyc;
                done_flags_b = {busy_b, valid_b};
            end
        end
    end

    // ---------------- ready driver for instance A ----------------
    int ready_mode = 0;   // 0 always high, 1 random, 2 two directed 5-cycle stalls
    int stall_cnt  = 0;
    bit stall1 = 1'b0, stall2 = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: ready_a = ($urandom_range(0, 3) != 0);
                2: begin
                    if (stall_cnt > 0) begin
                        ready_a = 1'b0; stall_cnt--;
                    end else if (!stall1 && log_a.size() >= 5) begin
                        stall1 = 1'b1; stall_cnt = 4; ready_a = 1'b0;
                    end else if (!stall2 && valid_a && kind_a) begin
                        stall2 = 1'b1; stall_cnt = 4; ready_a = 1'b0;
                    end else begin
                        ready_a = 1'b1;
                    end
                end
                default: ready_a = 1'b1;
            endcase
        end
    end

    // ---------------- reference model + dump checking ----------------
    task automatic check_dump(input bit sel, input int nbytes);
        tb_beat_t exp_q[$];
        tb_beat_t got[$];
        int       gc[$];
        int       nwords, dcyc;
        logic [1:0]  dflags;
        logic [31:0] w;
        for (int r = 0; r < 32; r++) exp_q.push_back(mk(1'b0, 8'(r), regs[r], 1'b0));
        nwords = (nbytes + 3) / 4;
        for (int wi = 0; wi < nwords; wi++) begin
            w = 32'd0;
            for (int k = 0; k < 4; k++)
                if (wi * 4 + k < nbytes) w = w | (32'(mem[wi * 4 + k]) << (24 - 8 * k));
            exp_q.push_back(mk(1'b1, 8'(wi), w, wi == nwords - 1));
        end
        if (sel) begin got = log_b; gc = lcyc_b; dcyc = done_cyc_b; dflags = done_flags_b; end
        else     begin got = log_a; gc = lcyc_a; dcyc = done_cyc_a; dflags = done_flags_a; end
        chk("beat_count", 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("beat_%0d", i), 64'(got[i]), 64'(exp_q[i]));
        if (got.size() > 0) chk("done_after_last_beat", 64'(dcyc), 64'(gc[gc.size() - 1] + 1));
        chk("idle_at_done", 64'(dflags), 64'd0);
    endtask

    task automatic do_dump(input bit sel, input bit double_start, input bit check_timing);
        int dc0, start_cyc;
        if (sel) begin log_b.delete(); lcyc_b.delete(); dc0 = done_cnt_b; end
        else     begin log_a.delete(); lcyc_a.delete(); dc0 = done_cnt_a; end
        @(posedge clk); #1;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        chk("busy_after_start", 64'(sel ? busy_b : busy_a), 64'd1);
        if (double_start) begin
            repeat (10) @(posedge clk);
            #1 start_a = 1'b1;
            @(posedge clk); #1 start_a = 1'b0;
            repeat (50) @(posedge clk);
            #1 start_a = 1'b1;
            @(posedge clk); #1 start_a = 1'b0;
        end
        for (int i = 0; i < 3000; i++) begin
            if ((sel ? done_cnt_b : done_cnt_a) != dc0) break;
            @(negedge clk);
        end
        chk("done_seen", 64'((sel ? done_cnt_b : done_cnt_a) - dc0), 64'd1);
        repeat (20) @(negedge clk);
        chk("single_done", 64'((sel ? done_cnt_b : done_cnt_a) - dc0), 64'd1);
        check_dump(sel, sel ? 6 : 100);
        if (check_timing && !sel && lcyc_a.size() >= 32) begin
            chk("first_beat_cycle", 64'(lcyc_a[0]), 64'(start_cyc + 1));
            chk("regs_back_to_back", 64'(lcyc_a[31] - lcyc_a[0]), 64'd31);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"},     64'(busy_a),     64'd0);
        chk({tag, "_done"},     64'(done_a),     64'd0);
        chk({tag, "_valid"},    64'(valid_a),    64'd0);
        chk({tag, "_last"},     64'(last_a),     64'd0);
        chk({tag, "_kind"},     64'(kind_a),     64'd0);
        chk({tag, "_index"},    64'(index_a),    64'd0);
        chk({tag, "_data"},     64'(data_a),     64'd0);
        chk({tag, "_reg_addr"}, 64'(reg_addr_a), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr_a), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    vec_t vecs [8];

    initial begin
        int dc;
        vecs[0] = '{1'b0, 0,  mk(1'b0, 8'd0,  32'h0000_0000, 1'b0)};
        vecs[1] = '{1'b0, 9,  mk(1'b0, 8'd9,  32'h0000_0005, 1'b0)};
        vecs[2] = '{1'b0, 11, mk(1'b0, 8'd11, 32'hFFFF_FFEC, 1'b0)};
        vecs[3] = '{1'b0, 24, mk(1'b0, 8'd24, 32'hFFFF_FF00, 1'b0)};
        vecs[4] = '{1'b0, 32, mk(1'b1, 8'd0,  32'h0000_0FFF, 1'b0)};
        vecs[5] = '{1'b0, 56, mk(1'b1, 8'd24, 32'hDEAD_BEEF, 1'b1)};
        vecs[6] = '{1'b1, 32, mk(1'b1, 8'd0,  32'h0000_0FFF, 1'b0)};
        vecs[7] = '{1'b1, 33, mk(1'b1, 8'd1,  32'hAABB_0000, 1'b1)};

        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'd0; regs[9] = 32'd5; regs[11] = 32'hFFFF_FFEC; regs[24] = 32'hFFFF_FF00;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h0F; mem[3] = 8'hFF;
        mem[4] = 8'hAA; mem[5] = 8'hBB; mem[6] = 8'h11; mem[7] = 8'h22;
        mem[96] = 8'hDE; mem[97] = 8'hAD; mem[98] = 8'hBE; mem[99] = 8'hEF;

        #2 rst_n_a = 1'b0; rst_n_b = 1'b0;
        #5 chk_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n_a = 1'b1; rst_n_b = 1'b1;
        repeat (2) @(negedge clk);
        chk_outputs_zero("idle");

        // Ready always high: back-to-back register beats, full dump
        ready_mode = 0;
        do_dump(1'b0, 1'b0, 1'b1);
        first_a = log_a;
        do_dump(1'b1, 1'b0, 1'b0);
        first_b = log_b;

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].sel) begin
                if (vecs[i].beat < first_b.size())
                    chk($sformatf("vec_%0d", i), 64'(first_b[vecs[i].beat]), 64'(vecs[i].exp));
                else
                    chk($sformatf("vec_%0d_present", i), 64'(first_b.size()), 64'(vecs[i].beat + 1));
            end else begin
                if (vecs[i].beat < first_a.size())
                    chk($sformatf("vec_%0d", i), 64'(first_a[vecs[i].beat]), 64'(vecs[i].exp));
                else
                    chk($sformatf("vec_%0d_present", i), 64'(first_a.size()), 64'(vecs[i].beat + 1));
            end
        end

        // Directed stalls in REGS and at the first memory word, plus extra starts
        stall1 = 1'b0; stall2 = 1'b0; stall_cnt = 0;
        ready_mode = 2;
        do_dump(1'b0, 1'b1, 1'b0);
        ready_mode = 0;

        // Reset in the middle of the memory phase
        log_a.delete(); lcyc_a.delete();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        for (int i = 0; i < 500 && log_a.size() < 40; i++) @(negedge clk);
        chk("reach_mid_memory", 64'(log_a.size() >= 40), 64'd1);
        dc = done_cnt_a;
        @(negedge clk);
        #2 rst_n_a = 1'b0;
        #1 chk_outputs_zero("abort");
        repeat (3) @(posedge clk);
        #1 rst_n_a = 1'b1;
        repeat (5) @(negedge clk);
        chk("no_done_after_abort", 64'(done_cnt_a), 64'(dc));
        do_dump(1'b0, 1'b0, 1'b1);

        // Randomized contents and backpressure
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
            ready_mode = 1;
            do_dump(1'b0, 1'b0, 1'b0);
            ready_mode = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mips_state_dumper.md
MIPS_STATE_DUMPER -- requirements
Module: mips_state_dumper

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 100, meaning the number of data-memory bytes dumped after the register file (1..1024).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a dump.
REQ-005 SHALL have port busy  output  1  high from accepted start until done.
REQ-006 SHALL have port done  output  1  one-cycle pulse after the final beat is accepted.
REQ-007 SHALL have port reg_rd_addr  output  5  register-file read index.
REQ-008 SHALL have port reg_rd_data  input  32  register-file data, combinational from reg_rd_addr.
REQ-009 SHALL have port mem_rd_addr  output  10  data-memory byte address.
REQ-010 SHALL have port mem_rd_data  input  8  data-memory byte, combinational from mem_rd_addr.
REQ-011 SHALL have port dump_valid  output  1  beat present.
REQ-012 SHALL have port dump_ready  input  1  sink accepts the beat.
REQ-013 SHALL have port dump_data  output  32  beat payload.
REQ-014 SHALL have port dump_kind  output  1  0 = register beat, 1 = memory-word beat.
REQ-015 SHALL have port dump_index  output  8  register number, or memory word index (byte address / 4).
REQ-016 SHALL have port dump_last  output  1  high on the final beat only.

Function
REQ-017 SHALL implement FSM states IDLE, REGS, MEM_GATHER, MEM_WAIT, FINISH.
REQ-018 IDLE + start -> REGS; start SHALL be ignored in any other state.
REQ-019 A handshake SHALL occur on a cycle with dump_valid and dump_ready both high; dump_data/kind/index/last SHALL stay stable while dump_valid is high and dump_ready is low.
REQ-020 The output slot SHALL be loadable when dump_valid is low or a handshake occurs that cycle.
REQ-021 REGS: registers 0..31 SHALL be emitted in order, one per loadable cycle; the first beat (register 0) SHALL be valid the cycle after start; with dump_ready held high, 32 beats in 32 consecutive cycles.
REQ-022 After loading register 31, the FSM SHALL move to MEM_GATHER.
REQ-023 MEM_GATHER SHALL read one byte per cycle and pack 4 bytes big-endian (lowest address into bits 31:24).
REQ-024 Bytes at addresses >= MEM_BYTES SHALL NOT be read; their lanes SHALL be zero, so the final partial word is zero-padded.
REQ-025 On the 4th byte of a word (or the last valid byte), the word SHALL load into the slot if it is loadable, otherwise the FSM SHALL hold in MEM_WAIT with the word captured until the slot becomes loadable.
REQ-026 The total number of memory beats SHALL be ceil(MEM_BYTES/4); dump_last SHALL be set on the final memory beat.
REQ-027 The FSM SHALL enter FINISH on the handshake of the last beat; done SHALL pulse the next cycle, with busy low from that cycle and the state returning to IDLE.
REQ-028 mem_rd_addr and reg_rd_addr SHALL be registered state; their values outside active reads are don't-care.

Reset
REQ-029 With rst_n low, the block SHALL asynchronously enter IDLE with busy, done, dump_valid, dump_last, dump_kind, dump_index and dump_data at 0, and reg_rd_addr and mem_rd_addr at 0.
REQ-030 Reset mid-dump SHALL abort the dump with no done pulse; a new start after release SHALL restart at register 0.

Structure
REQ-031 The FSM state enum, REG_COUNT=32 and BYTES_PER_WORD=4 SHALL live in shared package mips_pkg.
REQ-032 Byte packing SHALL be one sub-module, dump_word_packer (byte shift-in, lane count, zero-pad, word-complete flag).

Verification
REQ-033 Stimulus: reg model with $t1=5, $t3=0xFFFFFFEC, $t8=0xFFFFFF00; start with ready always high -> beats 0..31 in 32 consecutive cycles, beat 9 data=5, beat 11 data=0xFFFFFFEC, beat 24 data=0xFFFFFF00.
REQ-034 Stimulus: mem bytes 0..3 = 00 00 0F FF -> first memory beat has kind=1, index=0, data=0x00000FFF.
REQ-035 Stimulus: MEM_BYTES=6, bytes 4..5 = AA BB -> last beat index=1, data=0xAABB0000, dump_last=1, then done on the next cycle; 34 beats in total.
REQ-036 Stimulus: dump_ready low for 5 cycles during REGS and again at the first memory word -> payload stable throughout, no beat lost or duplicated, all 57 beats delivered for MEM_BYTES=100.
REQ-037 Stimulus: start pulsed again while busy -> ignored, single done; rst_n asserted mid-memory -> all outputs 0 immediately, no done, and a following start delivers register 0 first.
